// File: rtl/io_region_demux.sv
// Registered request router for the external-I/O window: base/length rule decode,
// one-hot forwarding with region-relative offset, in-order decode errors, outstanding-count gating.
module io_region_demux #(
  parameter int unsigned NrRules        = 6,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RuleBase = {
    64'h4500_0000, 64'h4400_0000, 64'h4300_0000,
    64'h4200_0000, 64'h4100_0000, 64'h4000_0000},
  parameter logic [NrRules-1:0][AddrWidth-1:0] RuleLength = {
    64'h10_0000, 64'h1_0000, 64'h1_0000,
    64'h1_0000,  64'h1_0000, 64'h1_0000},
  localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NrRules-1:0]   out_sel_o,
  output logic [IdxWidth-1:0]  out_idx_o,
  output logic [AddrWidth-1:0] out_offset_o,
  input  logic                 rsp_done_i,
  output logic                 err_valid_o,
  input  logic                 err_ready_i,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 underflow_o
);

  typedef enum logic [1:0] {StEmpty, StFwd, StErr} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [AddrWidth-1:0]   off_q, off_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [IdxWidth-1:0]    cur_idx_q, cur_idx_d;
  logic                   underflow_q, underflow_d;

  logic                   dec_hit;
  logic [IdxWidth-1:0]    dec_idx;
  logic [AddrWidth-1:0]   dec_off;
  logic [AddrWidth:0]     rule_end;
  logic                   out_fire, err_fire, q_fire, accept;

  // Rule end is one bit wider so a region touching the top of the space cannot wrap.
  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_off  = '0;
    rule_end = '0;
    for (int unsigned i = 0; i < NrRules; i++) begin
      rule_end = {1'b0, RuleBase[i]} + {1'b0, RuleLength[i]};
      if (!dec_hit && (RuleLength[i] != '0) && (req_addr_i >= RuleBase[i]) &&
          ({1'b0, req_addr_i} < rule_end)) begin
        dec_hit = 1'b1;
        dec_idx = IdxWidth'(i);
        dec_off = req_addr_i - RuleBase[i];
      end
    end
  end

  always_comb begin
    out_valid_o   = (state_q == StFwd) &&
                    ((cnt_q == '0) ||
                     ((cur_idx_q == idx_q) && (cnt_q < CntWidth'(MaxOutstanding))));
    err_valid_o   = (state_q == StErr) && (cnt_q == '0);
    out_fire      = out_valid_o && out_ready_i;
    err_fire      = err_valid_o && err_ready_i;
    q_fire        = out_fire || err_fire;
    req_ready_o   = (state_q == StEmpty) || q_fire;
    accept        = req_valid_i && req_ready_o;
    out_sel_o     = out_valid_o ? (NrRules'(1) << idx_q) : '0;
    out_idx_o     = idx_q;
    out_offset_o  = off_q;
    err_addr_o    = addr_q;
    outstanding_o = cnt_q;
    underflow_o   = underflow_q;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    off_d       = off_q;
    cur_idx_d   = cur_idx_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    if (accept) begin
      state_d = dec_hit ? StFwd : StErr;
      addr_d  = req_addr_i;
      idx_d   = dec_idx;
      off_d   = dec_off;
    end else if (q_fire) begin
      state_d = StEmpty;
    end
    if (out_fire) cur_idx_d = idx_q;
    // A response arriving together with an issue cancels out; a lone one at zero is an underflow.
    unique case ({out_fire, rsp_done_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01: begin
        if (cnt_q == '0) underflow_d = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      addr_q      <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      cur_idx_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      cur_idx_q   <= cur_idx_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
